// File: rtl/bp_pkg.sv
// Shared encodings and PC field geometry for the branch predictor.
package bp_pkg;

    localparam int PC_W   = 32;
    localparam int PC_LSB = 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    localparam cnt_e CNT_INIT_BR  = WT;
    localparam cnt_e CNT_INIT_JMP = ST;
    localparam cnt_e CNT_RESET    = WNT;

    // Width of the tag that remains once index and byte-offset bits are removed.
    function automatic int tag_width(input int idx_w);
        return PC_W - PC_LSB - idx_w;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    input  logic       force_st,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (force_st) begin
            nxt = ST;
        end else if (taken) begin
            if (cur != ST) nxt = cur + 2'd1;
        end else begin
            if (cur != SNT) nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; combinational lookup, one training update per cycle.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int TAG_W = 30 - IDX_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      fetch_pc,
    output logic             pr,
    output logic [31:0]      pr_addr,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_is_jump,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    logic             valid_vec  [ENTRIES];
    logic [TAG_W-1:0] tag_vec    [ENTRIES];
    logic [31:0]      target_vec [ENTRIES];
    logic [1:0]       cnt_vec    [ENTRIES];

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_hit;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             wr_en;
    logic             tgt_wr;
    logic [1:0]       cnt_sat;
    logic [1:0]       cnt_new;

    logic [CNT_W-1:0] mispred_cnt_reg;
    logic             unused_pc_bits;

    // Byte-offset bits never participate in index or tag.
    assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

    assign fetch_idx = fetch_pc[IDX_W+PC_LSB-1:PC_LSB];
    assign fetch_tag = fetch_pc[31:IDX_W+PC_LSB];
    assign fetch_hit = valid_vec[fetch_idx] && (tag_vec[fetch_idx] == fetch_tag);
    assign pr        = fetch_hit && cnt_vec[fetch_idx][1];
    assign pr_addr   = pr ? target_vec[fetch_idx] : 32'd0;

    assign upd_idx = upd_pc[IDX_W+PC_LSB-1:PC_LSB];
    assign upd_tag = upd_pc[31:IDX_W+PC_LSB];
    assign upd_hit = valid_vec[upd_idx] && (tag_vec[upd_idx] == upd_tag);

    // A miss that was not taken leaves the table untouched; everything else writes.
    assign wr_en  = upd_valid && (upd_hit || upd_taken);
    assign tgt_wr = upd_is_jump || upd_taken;

    sat_counter2 u_sat (
        .cur      (cnt_vec[upd_idx]),
        .taken    (upd_taken),
        .force_st (upd_is_jump),
        .nxt      (cnt_sat)
    );

    always_comb begin
        cnt_new = cnt_sat;
        if (!upd_hit) cnt_new = upd_is_jump ? CNT_INIT_JMP : CNT_INIT_BR;
    end

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic             valid_reg;
        logic [TAG_W-1:0] tag_reg;
        logic [31:0]      target_reg;
        logic [1:0]       cnt_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_reg  <= 1'b0;
                tag_reg    <= '0;
                target_reg <= '0;
                cnt_reg    <= CNT_RESET;
            end else if (wr_en && (upd_idx == IDX_W'(gi))) begin
                valid_reg <= 1'b1;
                tag_reg   <= upd_tag;
                cnt_reg   <= cnt_new;
                if (tgt_wr) target_reg <= upd_target;
            end
        end

        assign valid_vec[gi]  = valid_reg;
        assign tag_vec[gi]    = tag_reg;
        assign target_vec[gi] = target_reg;
        assign cnt_vec[gi]    = cnt_reg;
    end

    // Direction mispredicts only; wrong-target cases are accounted for in EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispred_cnt_reg <= '0;
        end else if (upd_valid && (upd_pred != upd_taken) && (mispred_cnt_reg != '1)) begin
            mispred_cnt_reg <= mispred_cnt_reg + 1'b1;
        end
    end

    assign mispred_cnt = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor: table of per-cycle stimulus plus reset/saturation sequences.
module tb_branch_predictor;

    localparam int IDX_W = 4;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic [31:0]      fetch_pc;
    logic             pr;
    logic [31:0]      pr_addr;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_is_jump;
    logic             upd_taken;
    logic [31:0]      upd_target;
    logic             upd_pred;
    logic [CNT_W-1:0] mispred_cnt;

    int checks;
    int errors;

    branch_predictor #(.IDX_W(IDX_W), .TAG_W(30 - IDX_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_pc    (fetch_pc),
        .pr          (pr),
        .pr_addr     (pr_addr),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_is_jump (upd_is_jump),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_pred    (upd_pred),
        .mispred_cnt (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fpc;
        logic        uv;
        logic [31:0] upc;
        logic        uj;
        logic        ut;
        logic [31:0] utg;
        logic        up;
        logic        epr;
        logic [31:0] eaddr;
        logic [15:0] emc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                                input logic uj, input logic ut, input logic [31:0] utg,
                                input logic up, input logic epr, input logic [31:0] eaddr,
                                input logic [15:0] emc);
        vec_t v;
        v.fpc = fpc; v.uv = uv; v.upc = upc; v.uj = uj; v.ut = ut; v.utg = utg;
        v.up = up; v.epr = epr; v.eaddr = eaddr; v.emc = emc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_upd();
        upd_valid = 1'b0; upd_pc = 32'd0; upd_is_jump = 1'b0;
        upd_taken = 1'b0; upd_target = 32'd0; upd_pred = 1'b0;
    endtask

    // Expected pr/pr_addr/mispred_cnt are sampled before the edge that applies the update.
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        fetch_pc = 32'h104C0;
        idle_upd();

        //          fetch     uv  upc       uj  ut  target    up  pr  addr      mcnt
        vecs.push_back(mk(32'h104C0, 0, 32'h0,     0, 0, 32'h0,     0, 0, 32'h0,     0));
        vecs.push_back(mk(32'h0,     0, 32'h0,     0, 0, 32'h0,     0, 0, 32'h0,     0));
        vecs.push_back(mk(32'h104C0, 1, 32'h104C0, 0, 1, 32'h10400, 0, 0, 32'h0,     0));
        vecs.push_back(mk(32'h104C0, 0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h10400, 1));
        vecs.push_back(mk(32'h10500, 0, 32'h0,     0, 0, 32'h0,     0, 0, 32'h0,     1));
        vecs.push_back(mk(32'h104C0, 1, 32'h104C0, 0, 0, 32'h0,     1, 1, 32'h10400, 1));
        vecs.push_back(mk(32'h104C0, 1, 32'h104C0, 0, 0, 32'h0,     0, 0, 32'h0,     2));
        vecs.push_back(mk(32'h104C0, 1, 32'h104C0, 0, 0, 32'h0,     0, 0, 32'h0,     2));
        vecs.push_back(mk(32'h104C0, 1, 32'h104C0, 0, 1, 32'h10400, 0, 0, 32'h0,     2));
        vecs.push_back(mk(32'h104C0, 0, 32'h0,     0, 0, 32'h0,     0, 0, 32'h0,     3));
        vecs.push_back(mk(32'h104C0, 1, 32'h104C0, 0, 1, 32'h10444, 0, 0, 32'h0,     3));
        vecs.push_back(mk(32'h104C0, 0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h10444, 4));
        vecs.push_back(mk(32'h104C0, 1, 32'h104C0, 0, 1, 32'h10444, 1, 1, 32'h10444, 4));
        vecs.push_back(mk(32'h104C0, 1, 32'h104C0, 0, 0, 32'h0,     1, 1, 32'h10444, 4));
        vecs.push_back(mk(32'h104C0, 1, 32'h104C0, 0, 1, 32'h10444, 1, 1, 32'h10444, 5));
        vecs.push_back(mk(32'h104C0, 1, 32'h104C0, 0, 1, 32'h10444, 1, 1, 32'h10444, 5));
        vecs.push_back(mk(32'h104C0, 1, 32'h104C0, 0, 0, 32'h0,     1, 1, 32'h10444, 5));
        vecs.push_back(mk(32'h104C0, 1, 32'h104C0, 0, 0, 32'h0,     1, 1, 32'h10444, 6));
        vecs.push_back(mk(32'h104C0, 0, 32'h0,     0, 0, 32'h0,     0, 0, 32'h0,     7));
        // alias at idx 0: jump allocation evicts 0x104C0, invisible in its own cycle
        vecs.push_back(mk(32'h10500, 1, 32'h10500, 1, 1, 32'h20000, 0, 0, 32'h0,     7));
        vecs.push_back(mk(32'h10500, 0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h20000, 8));
        vecs.push_back(mk(32'h104C0, 0, 32'h0,     0, 0, 32'h0,     0, 0, 32'h0,     8));
        // not-taken miss must not allocate
        vecs.push_back(mk(32'h0,     1, 32'h200,   0, 0, 32'h0,     0, 0, 32'h0,     8));
        vecs.push_back(mk(32'h200,   0, 32'h0,     0, 0, 32'h0,     0, 0, 32'h0,     8));
        vecs.push_back(mk(32'h10500, 0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h20000, 8));
        // branch allocates weakly taken
        vecs.push_back(mk(32'h0,     1, 32'h204,   0, 1, 32'h300,   0, 0, 32'h0,     8));
        vecs.push_back(mk(32'h204,   0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h300,   9));
        vecs.push_back(mk(32'h0,     1, 32'h204,   0, 0, 32'h0,     1, 0, 32'h0,     9));
        vecs.push_back(mk(32'h204,   0, 32'h0,     0, 0, 32'h0,     0, 0, 32'h0,     10));
        // jump hit forces strongly taken and rewrites target
        vecs.push_back(mk(32'h0,     1, 32'h204,   1, 1, 32'h400,   0, 0, 32'h0,     10));
        vecs.push_back(mk(32'h204,   0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h400,   11));
        vecs.push_back(mk(32'h0,     1, 32'h204,   0, 0, 32'h0,     1, 0, 32'h0,     11));
        vecs.push_back(mk(32'h204,   0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h400,   12));
        // unknown update fields while upd_valid=0
        vecs.push_back(mk(32'h204,   0, 'x,        'x, 'x, 'x,      'x, 1, 32'h400,  12));
        vecs.push_back(mk(32'h204,   0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h400,   12));

        @(negedge clk);
        #1;
        check("reset_pr", {31'd0, pr}, 32'd0);
        check("reset_addr", pr_addr, 32'd0);
        check("reset_mcnt", {16'd0, mispred_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            fetch_pc    = vecs[i].fpc;
            upd_valid   = vecs[i].uv;
            upd_pc      = vecs[i].upc;
            upd_is_jump = vecs[i].uj;
            upd_taken   = vecs[i].ut;
            upd_target  = vecs[i].utg;
            upd_pred    = vecs[i].up;
            #1;
            check($sformatf("v%0d_pr", i), {31'd0, pr}, {31'd0, vecs[i].epr});
            check($sformatf("v%0d_addr", i), pr_addr, vecs[i].eaddr);
            check($sformatf("v%0d_mcnt", i), {16'd0, mispred_cnt}, {16'd0, vecs[i].emc});
            $display("vec %0d fetch=0x%08h pr=%0b addr=0x%08h mcnt=%0d", i, fetch_pc, pr, pr_addr, mispred_cnt);
        end

        // Mid-operation reset with a concurrent allocating update that must be dropped.
        @(negedge clk);
        fetch_pc = 32'h204;
        upd_valid = 1'b1; upd_pc = 32'h208; upd_is_jump = 1'b1;
        upd_taken = 1'b1; upd_target = 32'h500; upd_pred = 1'b0;
        #1;
        check("pre_rst_pr", {31'd0, pr}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_pr", {31'd0, pr}, 32'd0);
        check("async_rst_addr", pr_addr, 32'd0);
        check("async_rst_mcnt", {16'd0, mispred_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle_upd();
        fetch_pc = 32'h208;
        #1;
        check("rst_drop_upd_pr", {31'd0, pr}, 32'd0);
        check("rst_drop_upd_mcnt", {16'd0, mispred_cnt}, 32'd0);
        $display("reset seq fetch=0x%08h pr=%0b mcnt=%0d", fetch_pc, pr, mispred_cnt);

        // Drive 2**CNT_W+3 direction mispredicts on a non-allocating miss.
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h3000; upd_is_jump = 1'b0;
        upd_taken = 1'b0; upd_target = 32'h0; upd_pred = 1'b1;
        for (int n = 1; n <= (1 << CNT_W) + 3; n++) begin
            @(negedge clk);
            if (n == 1) check("mcnt_first", {16'd0, mispred_cnt}, 32'd1);
            if (n == (1 << CNT_W) - 1) check("mcnt_reach_max", {16'd0, mispred_cnt}, 32'hFFFF);
        end
        idle_upd();
        #1;
        check("mcnt_saturated", {16'd0, mispred_cnt}, 32'hFFFF);
        fetch_pc = 32'h3000;
        #1;
        check("sat_no_alloc_pr", {31'd0, pr}, 32'd0);
        $display("saturation seq mcnt=0x%04h", mispred_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
